// File: rtl/rr_mux_pipe.sv
// N-channel round-robin multiplexer with a single registered output stage and
// valid/ready handshakes. Optional fixed-priority mode: define RR_MUX_FIXED_PRIO_EN.
module rr_mux_pipe #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
`ifdef RR_MUX_FIXED_PRIO_EN
  ,
  input  logic             fixed_prio
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             found;
  logic             xfer;
  logic [SEL_W-1:0] gidx;
  logic [SEL_W-1:0] start;
  logic             freeze_ptr;
  int               idx;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign start      = fixed_prio ? '0 : ptr_q;
  assign freeze_ptr = fixed_prio;
`else
  assign start      = ptr_q;
  assign freeze_ptr = 1'b0;
`endif

  assign load = !out_valid_q || out_ready;

  // Scan from the start index, wrapping, and stop at the first valid channel.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gidx  = idx[SEL_W-1:0];
      end
    end
  end

  assign xfer     = rst_n && load && found;
  assign in_ready = xfer ? (N'(1) << gidx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gidx)*W +: W];
      out_sel_d   = gidx;
      if (!freeze_ptr) begin
        ptr_d = (gidx == SEL_W'(N-1)) ? '0 : gidx + 1'b1;
      end
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_pipe.sv
// Directed and random stimulus for rr_mux_pipe (N=4, W=8) against a
// behavioural model of the arbitration and output register.
module tb_rr_mux_pipe;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;
  logic           fixed_prio;
  logic [W-1:0]   dch [N];

  int errors = 0;
  int checks = 0;

  // Model state
  bit        m_valid;
  bit [7:0]  m_data;
  int        m_sel;
  int        m_ptr;

  assign in_data = {dch[3], dch[2], dch[1], dch[0]};

  rr_mux_pipe #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef RR_MUX_FIXED_PRIO_EN
    ,
    .fixed_prio(fixed_prio)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel granted by the arbiter given the current model pointer; -1 if none.
  function automatic int model_grant();
    int start;
    start = m_ptr;
`ifdef RR_MUX_FIXED_PRIO_EN
    if (fixed_prio) start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (in_valid[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // One clock: check ready before the edge, update model, check outputs after.
  task automatic cycle();
    int  g;
    bit  ld;
    logic [N-1:0] exp_rdy;
    #1;
    g  = model_grant();
    ld = !m_valid || out_ready;
    exp_rdy = (rst_n && ld && g >= 0) ? (N'(1) << g) : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    end else if (ld && g >= 0) begin
      m_valid = 1; m_data = dch[g]; m_sel = g;
`ifdef RR_MUX_FIXED_PRIO_EN
      if (!fixed_prio) m_ptr = (g + 1) % N;
`else
      m_ptr = (g + 1) % N;
`endif
    end else if (out_ready && m_valid) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    @(negedge clk);
  endtask

  initial begin
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [1:0] frozen_sel;
    logic [7:0] frozen_data;

    rst_n = 0; in_valid = '0; out_ready = 0; fixed_prio = 0;
    for (int i = 0; i < N; i++) dch[i] = 8'hA0 + 8'(i);
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    @(negedge clk);

    // Reset with idle inputs
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t1_ready_zero", 32'(in_ready), 32'h0);
    end
    rst_n = 1;

    // All channels valid, continuous drain: rotating order
    in_valid = 4'b1111; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_sel", 32'(out_sel), 32'(exp_seq[i]));
      chk("t2_data", 32'(out_data), 32'hA0 + 32'(exp_seq[i]));
    end

    // Wrap: reset ptr, grant ch2 so ptr=3, then 0101 -> ch0 then ch2
    in_valid = '0; rst_n = 0; cycle(); rst_n = 1;
    in_valid = 4'b0100; cycle();
    chk("t3_first", 32'(out_sel), 32'd2);
    in_valid = 4'b0101; cycle();
    chk("t3_wrap", 32'(out_sel), 32'd0);
    cycle();
    chk("t3_next", 32'(out_sel), 32'd2);

    // Stall: held beat stays frozen, nothing accepted
    in_valid = 4'b1111; out_ready = 0;
    cycle();
    frozen_sel = out_sel; frozen_data = out_data;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_ready", 32'(in_ready), 32'h0);
      chk("t4_sel_frozen", 32'(out_sel), 32'(frozen_sel));
      chk("t4_data_frozen", 32'(out_data), 32'(frozen_data));
    end
    out_ready = 1;
    cycle();
    chk("t4_release_valid", 32'(out_valid), 32'd1);

    // Reset while a stalled beat is held
    out_ready = 0; cycle();
    rst_n = 0; cycle();
    chk("t5_valid_after_rst", 32'(out_valid), 32'd0);
    rst_n = 1; out_ready = 1; in_valid = 4'b1111;
    cycle();
    chk("t5_first_grant", 32'(out_sel), 32'd0);

`ifdef RR_MUX_FIXED_PRIO_EN
    fixed_prio = 1; in_valid = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t6_fixed", 32'(out_sel), 32'd1);
    end
    fixed_prio = 0;
    for (int i = 0; i < 4; i++) cycle();
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) dch[c] = 8'($urandom);
      rst_n = ($urandom_range(0, 60) != 0);
`ifdef RR_MUX_FIXED_PRIO_EN
      fixed_prio = ($urandom_range(0, 4) == 0);
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
